invader_formation: RTL and testbench

Game-side owner of the invader grid state that the VGA controller renders and reports hits against. Holds the 55-invader alive mask and the formation's top-left position. Consumes the `frame` start-of-blanking pulse and the `invader_collision` hit code, and produces `invaders`, `invaders_x` and `invaders_y`. All updates land during blanking, so the video pipeline sees stable values for a whole active frame.

---
 rtl/invader_formation_pkg.sv | 35 +++
 rtl/invader_formation_bounds.sv | 44 ++++
 rtl/invader_formation.sv | 124 ++++++++++++
 tb/tb_invader_formation.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/invader_formation_pkg.sv
// Shared invader grid geometry, bounds and pacing, used by the game side
// and the VGA renderer so both agree on the formation layout.
package invader_formation_pkg;

    localparam int INVADERS_H = 11;
    localparam int INVADERS_V = 5;
    localparam int INVADERS_N = INVADERS_H * INVADERS_V;

    localparam logic [10:0] INVADERS_OFFSET_H = 11'd40;
    localparam logic [10:0] INVADERS_OFFSET_V = 11'd32;
    localparam logic [10:0] INVADER_W = 11'd24;
    localparam logic [10:0] INVADER_HT = 11'd16;
    localparam logic [10:0] START_X = 11'd100;
    localparam logic [10:0] START_Y = 11'd64;
    localparam logic [10:0] LEFT_BOUND = 11'd8;
    localparam logic [10:0] RIGHT_BOUND = 11'd632;
    localparam logic [10:0] BOTTOM_LIMIT = 11'd400;
    localparam logic [10:0] STEP_H = 11'd2;
    localparam logic [10:0] STEP_V = 11'd8;

    localparam logic [5:0] ALIVE_INIT = 6'd55;
    localparam logic [INVADERS_N-1:0] FULL_MASK = {INVADERS_N{1'b1}};

    localparam logic ST_RUN = 1'b0;
    localparam logic ST_HALT = 1'b1;

    // Frame-count threshold (period - 1): the wave speeds up as it thins out.
    function automatic logic [3:0] period_m1(input logic [5:0] alive);
        if (alive >= 6'd40) return 4'd15;
        else if (alive >= 6'd20) return 4'd7;
        else if (alive >= 6'd5) return 4'd3;
        else return 4'd0;
    endfunction

endpackage

// File: rtl/invader_formation_bounds.sv
// Occupied-extent finder for the alive mask: leftmost and rightmost
// occupied columns, lowest occupied row, and an empty flag.
module formation_bounds
    import invader_formation_pkg::*;
(
    input  logic [INVADERS_N-1:0] invaders,
    output logic [3:0]            col_l,
    output logic [3:0]            col_r,
    output logic [2:0]            row_b,
    output logic                  empty
);

    logic [INVADERS_H-1:0] col_any;
    logic [INVADERS_V-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < INVADERS_V; r++) begin
            for (int c = 0; c < INVADERS_H; c++) begin
                if (invaders[r*INVADERS_H+c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
    end

    // Later matches overwrite earlier ones, giving the priority direction.
    always_comb begin
        col_l = 4'd0;
        col_r = 4'd0;
        row_b = 3'd0;
        for (int c = INVADERS_H - 1; c >= 0; c--)
            if (col_any[c]) col_l = 4'(c);
        for (int c = 0; c < INVADERS_H; c++)
            if (col_any[c]) col_r = 4'(c);
        for (int r = 0; r < INVADERS_V; r++)
            if (row_any[r]) row_b = 3'(r);
    end

    assign empty = ~|col_any;

endmodule

// File: rtl/invader_formation.sv
// Invader wave state: alive mask, formation position, march pacing and
// end-of-wave detection. All changes follow the start-of-blanking pulse.
module invader_formation
    import invader_formation_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame,
    input  logic [5:0]            invader_collision,
    input  logic                  restart,
    output logic [INVADERS_N-1:0] invaders,
    output logic [9:0]            invaders_x,
    output logic [9:0]            invaders_y,
    output logic                  step,
    output logic                  anim,
    output logic                  all_dead,
    output logic                  landed
);

    logic                  state;
    logic [INVADERS_N-1:0] mask;
    logic [10:0]           x;
    logic [10:0]           y;
    logic                  dir_l;
    logic [3:0]            frame_cnt;
    logic [5:0]            alive_cnt;

    logic [3:0]            col_l;
    logic [3:0]            col_r;
    logic [2:0]            row_b;
    logic                  empty;

    formation_bounds u_bounds (
        .invaders (mask),
        .col_l    (col_l),
        .col_r    (col_r),
        .row_b    (row_b),
        .empty    (empty)
    );

    logic                  hit_ok;
    logic [5:0]            hit_idx;
    logic [INVADERS_N-1:0] hit_vec;
    logic                  hit;
    logic [INVADERS_N-1:0] mask_nxt;
    logic                  move;
    logic                  rev_r;
    logic                  rev_l;
    logic                  land;

    always_comb begin
        hit_ok   = (invader_collision != 6'd0) && (invader_collision <= 6'd55);
        hit_idx  = invader_collision - 6'd1;
        hit_vec  = hit_ok ? (INVADERS_N'(1) << hit_idx) : '0;
        hit      = |(hit_vec & mask);
        mask_nxt = hit ? (mask & ~hit_vec) : mask;
    end

    always_comb begin
        move  = frame && (frame_cnt >= period_m1(alive_cnt));
        rev_r = (x + 11'(col_r) * INVADERS_OFFSET_H + INVADER_W + STEP_H)
                > RIGHT_BOUND;
        rev_l = (x + 11'(col_l) * INVADERS_OFFSET_H) < (LEFT_BOUND + STEP_H);
        // Landing is judged on the position the previous move produced.
        land  = step
                && (y + 11'(row_b) * INVADERS_OFFSET_V + INVADER_HT)
                   >= BOTTOM_LIMIT;
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state     <= ST_RUN;
            mask      <= FULL_MASK;
            x         <= START_X;
            y         <= START_Y;
            dir_l     <= 1'b0;
            frame_cnt <= 4'd0;
            alive_cnt <= ALIVE_INIT;
            step      <= 1'b0;
            anim      <= 1'b0;
            landed    <= 1'b0;
        end else begin
            step <= 1'b0;
            if (state == ST_RUN) begin
                if (hit) begin
                    mask      <= mask_nxt;
                    alive_cnt <= alive_cnt - 6'd1;
                end
                if (frame) begin
                    if (move) begin
                        frame_cnt <= 4'd0;
                        step      <= 1'b1;
                        anim      <= ~anim;
                        if (!dir_l) begin
                            if (rev_r) begin
                                y     <= y + STEP_V;
                                dir_l <= 1'b1;
                            end else begin
                                x <= x + STEP_H;
                            end
                        end else begin
                            if (rev_l) begin
                                y     <= y + STEP_V;
                                dir_l <= 1'b0;
                            end else begin
                                x <= x - STEP_H;
                            end
                        end
                    end else begin
                        frame_cnt <= frame_cnt + 4'd1;
                    end
                end
                if (land) landed <= 1'b1;
                if (land || (mask_nxt == '0)) state <= ST_HALT;
            end
        end
    end

    assign invaders   = mask;
    assign invaders_x = x[9:0];
    assign invaders_y = y[9:0];
    assign all_dead   = empty;

endmodule

// File: tb/tb_invader_formation.sv
// Randomised and directed bench for invader_formation against a
// behavioural wave model kept in plain integers and arrays.
module tb_invader_formation;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame;
    logic [5:0]  invader_collision;
    logic        restart;
    logic [54:0] invaders;
    logic [9:0]  invaders_x;
    logic [9:0]  invaders_y;
    logic        step;
    logic        anim;
    logic        all_dead;
    logic        landed;

    int vectors = 0;
    int miscompares = 0;

    invader_formation dut (
        .clk               (clk),
        .rst               (rst),
        .frame             (frame),
        .invader_collision (invader_collision),
        .restart           (restart),
        .invaders          (invaders),
        .invaders_x        (invaders_x),
        .invaders_y        (invaders_y),
        .step              (step),
        .anim              (anim),
        .all_dead          (all_dead),
        .landed            (landed)
    );

    always #5 clk = ~clk;

    bit m_alive[55];
    int m_cnt, m_x, m_y, m_fcnt;
    bit m_left, m_step, m_anim, m_landed, m_halt;

    task automatic m_reload();
        foreach (m_alive[i]) m_alive[i] = 1'b1;
        m_cnt = 55; m_x = 100; m_y = 64; m_fcnt = 0;
        m_left = 0; m_step = 0; m_anim = 0; m_landed = 0; m_halt = 0;
    endtask

    task automatic m_update(bit f, int code, bit rs, bit r);
        int cl, cr, rb, per;
        bit land, nstep;
        if (r || rs) begin
            m_reload();
            return;
        end
        nstep = 0;
        if (!m_halt) begin
            cl = 99; cr = -1; rb = -1;
            for (int row = 0; row < 5; row++)
                for (int col = 0; col < 11; col++)
                    if (m_alive[row*11+col]) begin
                        if (col < cl) cl = col;
                        if (col > cr) cr = col;
                        if (row > rb) rb = row;
                    end
            per = (m_cnt >= 40) ? 16 : (m_cnt >= 20) ? 8 : (m_cnt >= 5) ? 4 : 1;
            land = m_step && (m_y + rb * 32 + 16 >= 400);
            if (code >= 1 && code <= 55 && m_alive[code-1]) begin
                m_alive[code-1] = 0;
                m_cnt--;
            end
            if (f) begin
                if (m_fcnt >= per - 1) begin
                    m_fcnt = 0;
                    nstep = 1;
                    m_anim = !m_anim;
                    if (!m_left) begin
                        if (m_x + cr * 40 + 24 + 2 > 632) begin
                            m_y += 8; m_left = 1;
                        end else m_x += 2;
                    end else begin
                        if (m_x + cl * 40 < 8 + 2) begin
                            m_y += 8; m_left = 0;
                        end else m_x -= 2;
                    end
                end else m_fcnt++;
            end
            if (land) begin
                m_landed = 1; m_halt = 1;
            end
            if (m_cnt == 0) m_halt = 1;
        end
        m_step = nstep;
    endtask

    function automatic logic [54:0] m_mask();
        logic [54:0] v;
        foreach (m_alive[i]) v[i] = m_alive[i];
        return v;
    endfunction

    task automatic cmp(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        cmp("mask", longint'(invaders), longint'(m_mask()));
        cmp("x", longint'(invaders_x), longint'(m_x));
        cmp("y", longint'(invaders_y), longint'(m_y));
        cmp("step", longint'(step), longint'(m_step));
        cmp("anim", longint'(anim), longint'(m_anim));
        cmp("all_dead", longint'(all_dead), longint'(m_cnt == 0));
        cmp("landed", longint'(landed), longint'(m_landed));
    endtask

    task automatic tick(bit f, int code, bit rs, bit r);
        frame = f;
        invader_collision = 6'(code);
        restart = rs;
        rst = r;
        m_update(f, code, rs, r);
        @(negedge clk);
        compare_model();
    endtask

    task automatic frame_tick();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    task automatic kill(int idx);
        tick(0, idx + 1, 0, 0);
    endtask

    int n;

    initial begin
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        cmp("rst_mask", longint'(invaders), 64'h7FFFFFFFFFFFFF);
        cmp("rst_x", longint'(invaders_x), 100);
        cmp("rst_y", longint'(invaders_y), 64);
        cmp("rst_flags", longint'({step, anim, all_dead, landed}), 0);

        n = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1, 0, 0, 0);
            if (step) n++;
            tick(0, 0, 0, 0);
            if (step) n++;
        end
        cmp("first_move_x", longint'(invaders_x), 102);
        cmp("first_move_steps", longint'(n), 1);

        tick(0, 1, 0, 0);
        cmp("hit1_bit0", longint'(invaders[0]), 0);
        tick(0, 1, 0, 0);
        tick(0, 60, 0, 0);
        cmp("hit_ignored", longint'(invaders), 64'h7FFFFFFFFFFFFE);

        for (int i = 0; i < 4000 && invaders_y == 10'd64; i++) frame_tick();
        cmp("full_rev_x", longint'(invaders_x), 208);
        cmp("full_rev_y", longint'(invaders_y), 72);

        tick(0, 0, 1, 0);
        for (int r = 0; r < 5; r++)
            for (int c = 8; c < 11; c++) kill(r * 11 + c);
        for (int i = 0; i < 5000 && invaders_y == 10'd64; i++) frame_tick();
        cmp("narrow_rev_x", longint'(invaders_x), 328);
        cmp("narrow_rev_y", longint'(invaders_y), 72);

        tick(0, 0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            int code;
            code = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 0;
            tick($urandom_range(0, 3) == 0, code, $urandom_range(0, 399) == 0,
                 $urandom_range(0, 1999) == 0);
        end

        tick(0, 0, 1, 0);
        for (int i = 4; i < 55; i++) kill(i);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            cmp("fast_period_step", longint'(step), 1);
            tick(0, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) kill(i);
        cmp("all_dead", longint'(all_dead), 1);
        for (int i = 0; i < 5; i++) frame_tick();
        cmp("dead_hold_x", longint'(invaders_x), 106);

        tick(0, 0, 1, 0);
        for (int i = 0; i < 55; i++)
            if (i < 44 || i > 47) kill(i);
        for (int i = 0; i < 8000 && !landed; i++) frame_tick();
        cmp("landed", longint'(landed), 1);
        cmp("landed_y", longint'(invaders_y), 256);
        for (int i = 0; i < 5; i++) frame_tick();

        tick(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) frame_tick();
        tick(1, 0, 1, 0);
        cmp("restart_x", longint'(invaders_x), 100);
        cmp("restart_step", longint'(step), 0);
        tick(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
